// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and defaults for the image-memory access sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_LDR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_if
// Purpose  : CPU, loader and memory-side signal bundle for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int ADDR_W = mem_ctrl_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_ctrl_pkg::DATA_W_DEF
) ();

    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              mdr_sel_mem;
    logic              mdr_we_mem;

    logic              ldr_req;
    logic              ldr_wr;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_wr, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_ack, mdr_sel_mem, mdr_we_mem,
        output ldr_rdata, ldr_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output ldr_req, ldr_wr, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_ack, mdr_sel_mem, mdr_we_mem,
        input  ldr_rdata, ldr_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter
// Purpose  : Two-input round-robin grant with last-granted register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    input  wire logic i_req_cpu,
    input  wire logic i_req_ldr,
    input  wire logic i_update,
    input  wire logic i_done_id,
    output logic      o_valid,
    output logic      o_grant
);

    req_id_t r_last_q;
    req_id_t w_last_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        o_grant = REQ_CPU;
        if (i_req_cpu && i_req_ldr) begin
            o_grant = (r_last_q == REQ_CPU) ? REQ_LDR : REQ_CPU;
        end else if (i_req_ldr) begin
            o_grant = REQ_LDR;
        end
    end

    assign o_valid = i_en && (i_req_cpu || i_req_ldr);

    always_comb begin
        w_last_d = r_last_q;
        if (i_update) begin
            w_last_d = i_done_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_q <= REQ_LDR;
        end else begin
            r_last_q <= w_last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Sequences CPU / image-loader accesses to external image memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_access_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_LAT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_e            r_state_q;
    state_e            w_state_d;
    req_id_t           r_grant_q;
    req_id_t           w_grant_d;
    logic              r_wr_q;
    logic              w_wr_d;
    logic [CNT_W-1:0]  r_cnt_q;
    logic [CNT_W-1:0]  w_cnt_d;
    logic [DATA_W-1:0] r_ldr_rdata_q;
    logic [DATA_W-1:0] w_ldr_rdata_d;

    logic              w_arb_valid;
    logic              w_arb_grant;
    logic              w_sel_ldr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    mem_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_state_q == ST_IDLE),
        .i_req_cpu (bus.cpu_req),
        .i_req_ldr (bus.ldr_req),
        .i_update  (r_state_q == ST_DONE),
        .i_done_id (r_grant_q),
        .o_valid   (w_arb_valid),
        .o_grant   (w_arb_grant)
    );

    // IDLE parks the muxes on the CPU side.
    assign w_sel_ldr     = (r_state_q != ST_IDLE) && (r_grant_q == REQ_LDR);
    assign w_addr        = w_sel_ldr ? bus.ldr_addr  : bus.cpu_addr;
    assign w_wdata       = w_sel_ldr ? bus.ldr_wdata : bus.cpu_wdata;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.ldr_rdata = r_ldr_rdata_q;
    assign bus.busy      = (r_state_q != ST_IDLE);

    always_comb begin
        w_state_d       = r_state_q;
        w_grant_d       = r_grant_q;
        w_wr_d          = r_wr_q;
        w_cnt_d         = r_cnt_q;
        w_ldr_rdata_d   = r_ldr_rdata_q;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mdr_sel_mem = 1'b0;
        bus.mdr_we_mem  = 1'b0;
        bus.cpu_ack     = 1'b0;
        bus.ldr_ack     = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_grant_d = w_arb_grant;
                    w_wr_d    = (w_arb_grant == REQ_LDR) ? bus.ldr_wr : bus.cpu_wr;
                    w_state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_we = r_wr_q;
                if (r_wr_q) begin
                    w_state_d = ST_DONE;
                end else if (MEM_LATENCY == 1) begin
                    w_state_d = ST_CAPTURE;
                end else begin
                    w_cnt_d   = c_LAT_LOAD;
                    w_state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                w_cnt_d = r_cnt_q - c_CNT_ONE;
                if (r_cnt_q == c_CNT_ONE) begin
                    w_state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (r_grant_q == REQ_CPU) begin
                    bus.mdr_sel_mem = 1'b1;
                    bus.mdr_we_mem  = 1'b1;
                end else begin
                    w_ldr_rdata_d = bus.mem_rdata;
                end
                w_state_d = ST_DONE;
            end
            ST_DONE: begin
                if (r_grant_q == REQ_CPU) begin
                    bus.cpu_ack = 1'b1;
                end else begin
                    bus.ldr_ack = 1'b1;
                end
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_grant_q     <= REQ_CPU;
            r_wr_q        <= 1'b0;
            r_cnt_q       <= '0;
            r_ldr_rdata_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_grant_q     <= w_grant_d;
            r_wr_q        <= w_wr_d;
            r_cnt_q       <= w_cnt_d;
            r_ldr_rdata_q <= w_ldr_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Scoreboard bench for mem_access_ctrl (latency 2 and latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int LAT = 2;

    typedef struct {
        bit         wr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(17), .DATA_W(8)) bus  ();
    mem_access_ctrl_if #(.ADDR_W(17), .DATA_W(8)) bus1 ();

    mem_access_ctrl #(.MEM_LATENCY(LAT), .ADDR_W(17), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_access_ctrl #(.MEM_LATENCY(1), .ADDR_W(17), .DATA_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    exp_t cpu_q[$];
    exp_t ldr_q[$];
    logic [7:0] ref_mem [logic [16:0]];
    logic [7:0] tb_mem  [logic [16:0]];

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] dflt(input logic [16:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [16:0] a);
        return tb_mem.exists(a) ? tb_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [16:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Reference model: each requester's accesses take effect in its own issue order.
    task automatic push_exp(input bit id, input bit wr, input logic [16:0] a, input logic [7:0] wd);
        exp_t e;
        e.wr = wr;
        if (wr) begin
            ref_mem[a] = wd;
            e.data = wd;
        end else begin
            e.data = ref_rd(a);
        end
        if (id) ldr_q.push_back(e);
        else    cpu_q.push_back(e);
    endtask

    // External memory: data for a read appears exactly LAT cycles after its strobe.
    logic [1:0] pv = 2'b00;
    logic [7:0] pd0 = 8'h00, pd1 = 8'h00, junk = 8'h00;
    logic       pv_b = 1'b0;
    logic [7:0] pd_b = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) tb_mem[bus.mem_addr] = bus.mem_wdata;
        if (bus1.mem_en && bus1.mem_we) tb_mem[bus1.mem_addr] = bus1.mem_wdata;
        pv   <= rst ? 2'b00 : {pv[0], bus.mem_en && !bus.mem_we};
        pd0  <= mem_rd(bus.mem_addr);
        pd1  <= pd0;
        pv_b <= rst ? 1'b0 : (bus1.mem_en && !bus1.mem_we);
        pd_b <= mem_rd(bus1.mem_addr);
        junk <= 8'($urandom);
    end
    assign bus.mem_rdata  = pv[1] ? pd1  : junk;
    assign bus1.mem_rdata = pv_b  ? pd_b : junk;

    // Monitor: pops the scoreboard whenever the DUT acknowledges.
    bit         cap_seen = 1'b0;
    logic [7:0] cap_data = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cap_seen = 1'b0;
        end else begin
            if (bus.mdr_we_mem || bus.mdr_sel_mem)
                chk("mdr_sel_eq_we", bus.mdr_we_mem == bus.mdr_sel_mem, {31'd0, bus.mdr_sel_mem}, {31'd0, bus.mdr_we_mem});
            if (bus.mdr_we_mem) begin
                cap_seen = 1'b1;
                cap_data = bus.mem_rdata;
            end
            if (bus.cpu_ack && bus.ldr_ack) chk("dual_ack", 1'b0, 32'd1, 32'd0);
            if (bus.cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_unexpected_ack", 1'b0, 32'd1, 32'd0);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.wr) chk("cpu_wr_no_mdr", !cap_seen, {31'd0, cap_seen}, 32'd0);
                    else      chk("cpu_rd_data", cap_seen && (cap_data == e.data), {24'd0, cap_data}, {24'd0, e.data});
                end
                cap_seen = 1'b0;
            end
            if (bus.ldr_ack) begin
                if (ldr_q.size() == 0) begin
                    chk("ldr_unexpected_ack", 1'b0, 32'd1, 32'd0);
                end else begin
                    e = ldr_q.pop_front();
                    if (!e.wr) chk("ldr_rd_data", bus.ldr_rdata == e.data, {24'd0, bus.ldr_rdata}, {24'd0, e.data});
                end
            end
        end
    end

    task automatic drive(input bit id, input bit req, input bit wr, input logic [16:0] a, input logic [7:0] wd);
        if (id) begin
            bus.ldr_req = req; bus.ldr_wr = wr; bus.ldr_addr = a; bus.ldr_wdata = wd;
        end else begin
            bus.cpu_req = req; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = wd;
        end
    endtask

    // Cycle 0 is the first cycle with req high; per-cycle strobe masks cover cycles 0..7.
    task automatic run_access(input bit id, input bit wr, input logic [16:0] a, input logic [7:0] wd,
                              output int ack_cyc, output logic [7:0] en_m, output logic [7:0] we_m,
                              output logic [7:0] mdr_m, output logic [16:0] iss_a, output logic [7:0] iss_wd);
        bit got_iss;
        push_exp(id, wr, a, wd);
        ack_cyc = -1; en_m = 8'h00; we_m = 8'h00; mdr_m = 8'h00;
        iss_a = '0; iss_wd = '0; got_iss = 1'b0;
        @(posedge clk); #1;
        drive(id, 1'b1, wr, a, wd);
        for (int k = 0; k < 60 && ack_cyc < 0; k++) begin
            @(negedge clk);
            if (k < 8) begin
                en_m[k]  = bus.mem_en;
                we_m[k]  = bus.mem_we;
                mdr_m[k] = bus.mdr_we_mem;
            end
            if (bus.mem_en && !got_iss) begin
                got_iss = 1'b1; iss_a = bus.mem_addr; iss_wd = bus.mem_wdata;
            end
            if (id ? bus.ldr_ack : bus.cpu_ack) ack_cyc = k;
        end
        if (ack_cyc < 0) chk(id ? "ldr_ack_timeout" : "cpu_ack_timeout", 1'b0, 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(id, 1'b0, wr, a, wd);
    endtask

    task automatic rand_stream(input bit id, input int n);
        int ac; logic [7:0] em, wm, mm; logic [16:0] ia; logic [7:0] iw;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_access(id, 1'($urandom_range(0, 1)), 17'($urandom_range(0, 15) * 2 + (id ? 1 : 0) + 17'h100),
                       8'($urandom), ac, em, wm, mm, ia, iw);
        end
    endtask

    initial begin
        int ac; logic [7:0] em, wm, mm; logic [16:0] ia; logic [7:0] iw;
        int order[4]; int cyc[4]; int nack; int stray;

        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        bus1.cpu_req = 0; bus1.cpu_wr = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
        bus1.ldr_req = 0; bus1.ldr_wr = 0; bus1.ldr_addr = '0; bus1.ldr_wdata = '0;
        tb_mem[17'h1FFFF] = 8'h3C; ref_mem[17'h1FFFF] = 8'h3C;
        tb_mem[17'h00200] = 8'h7E; ref_mem[17'h00200] = 8'h7E;
        tb_mem[17'h1F001] = 8'h99;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   bus.busy == 1'b0,      {31'd0, bus.busy}, 32'd0);
        chk("rst_mem_en", bus.mem_en == 1'b0,    {31'd0, bus.mem_en}, 32'd0);
        chk("rst_acks",   {bus.cpu_ack, bus.ldr_ack} == 2'b00, {30'd0, bus.cpu_ack, bus.ldr_ack}, 32'd0);
        chk("rst_rdata",  bus.ldr_rdata == 8'h00, {24'd0, bus.ldr_rdata}, 32'd0);
        chk("rst_mdr",    bus.mdr_we_mem == 1'b0, {31'd0, bus.mdr_we_mem}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // CPU write
        run_access(0, 1, 17'h00123, 8'hA5, ac, em, wm, mm, ia, iw);
        chk("wr_en_mask",  em == 8'b0000_0010, {24'd0, em}, 32'h02);
        chk("wr_we_mask",  wm == 8'b0000_0010, {24'd0, wm}, 32'h02);
        chk("wr_addr",     ia == 17'h00123, {15'd0, ia}, 32'h123);
        chk("wr_wdata",    iw == 8'hA5, {24'd0, iw}, 32'hA5);
        chk("wr_ack_cyc",  ac == 2, ac, 32'd2);

        // Loader read at top of memory
        run_access(1, 0, 17'h1FFFF, 8'h00, ac, em, wm, mm, ia, iw);
        chk("lrd_ack_cyc", ac == 2 + LAT, ac, 2 + LAT);
        chk("lrd_en_mask", em == 8'b0000_0010 && wm == 8'h00, {16'd0, em, wm}, 32'h0200);
        chk("lrd_no_mdr",  mm == 8'h00, {24'd0, mm}, 32'd0);
        chk("lrd_addr",    ia == 17'h1FFFF, {15'd0, ia}, 32'h1FFFF);
        repeat (2) @(negedge clk);
        chk("lrd_hold",    bus.ldr_rdata == 8'h3C, {24'd0, bus.ldr_rdata}, 32'h3C);

        // CPU read into MDR
        run_access(0, 0, 17'h00200, 8'h00, ac, em, wm, mm, ia, iw);
        chk("crd_mdr_mask", mm == 8'(1 << (1 + LAT)), {24'd0, mm}, 1 << (1 + LAT));
        chk("crd_ack_cyc",  ac == 2 + LAT, ac, 2 + LAT);

        // Both requesters held high from reset: alternate writes
        push_exp(0, 1, 17'h00010, 8'h11); push_exp(0, 1, 17'h00010, 8'h11);
        push_exp(1, 1, 17'h00011, 8'h33); push_exp(1, 1, 17'h00011, 8'h33);
        @(posedge clk); #1; rst = 1'b1;
        drive(0, 1, 1, 17'h00010, 8'h11);
        drive(1, 1, 1, 17'h00011, 8'h33);
        @(posedge clk); @(posedge clk); #1; rst = 1'b0;
        nack = 0;
        for (int k = 0; k < 40 && nack < 4; k++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.ldr_ack) begin
                order[nack] = bus.ldr_ack ? 1 : 0;
                cyc[nack] = k;
                nack++;
            end
        end
        @(posedge clk); #1;
        drive(0, 0, 1, 17'h00010, 8'h11);
        drive(1, 0, 1, 17'h00011, 8'h33);
        chk("rr_ack_count", nack == 4, nack, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < nack) begin
                chk("rr_order", order[i] == i % 2, order[i], i % 2);
                chk("rr_cycle", cyc[i] == 2 + 3 * i, cyc[i], 2 + 3 * i);
            end
        end

        // Reset while waiting on read latency
        @(posedge clk); #1;
        drive(0, 1, 0, 17'h00040, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("rdwait_busy", bus.busy == 1'b1 && bus.mem_en == 1'b0, {30'd0, bus.busy, bus.mem_en}, 32'h2);
        @(posedge clk); #1; rst = 1'b0;
        drive(0, 0, 0, 17'h00040, 8'h00);
        @(negedge clk);
        chk("abort_busy",   bus.busy == 1'b0,   {31'd0, bus.busy}, 32'd0);
        chk("abort_mem_en", bus.mem_en == 1'b0, {31'd0, bus.mem_en}, 32'd0);
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.ldr_ack) stray++;
        end
        chk("abort_no_ack", stray == 0, stray, 32'd0);
        run_access(1, 0, 17'h00021, 8'h00, ac, em, wm, mm, ia, iw);
        chk("post_abort_ack", ac == 2 + LAT, ac, 2 + LAT);

        // Latency-1 instance
        @(posedge clk); #1;
        bus1.ldr_req = 1; bus1.ldr_wr = 0; bus1.ldr_addr = 17'h1F001;
        ac = -1;
        for (int k = 0; k < 20 && ac < 0; k++) begin
            @(negedge clk);
            if (bus1.ldr_ack) begin
                ac = k;
                chk("lat1_rdata", bus1.ldr_rdata == 8'h99, {24'd0, bus1.ldr_rdata}, 32'h99);
            end
        end
        chk("lat1_ack_cyc", ac == 3, ac, 32'd3);
        @(posedge clk); #1; bus1.ldr_req = 0;

        // Randomised concurrent traffic
        fork
            rand_stream(0, 25);
            rand_stream(1, 25);
        join
        repeat (10) @(posedge clk);
        chk("cpu_q_empty", cpu_q.size() == 0, cpu_q.size(), 32'd0);
        chk("ldr_q_empty", ldr_q.size() == 0, ldr_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
